hash_table_ctrl: RTL and testbench

- Command sequencer that owns the slot memory of the hash table and runs LOOKUP, INSERT, DELETE and CLEAR on it.
- Collisions are resolved by linear probing. Deleted slots become tombstones.
- Sits between the tt_um_save_buffer_hash_table pin-level command decoder and a single-port, synchronous-read slot RAM.
- Exactly one command is in flight at a time.

---
 rtl/hash_table_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_hash_table_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_table_ctrl.sv
// Hash table command sequencer: runs LOOKUP / INSERT / DELETE / CLEAR against a
// single-port synchronous-read slot RAM using linear probing with tombstones.
module hash_table_ctrl #(
    parameter int unsigned KEY_W  = 8,
    parameter int unsigned VAL_W  = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [KEY_W-1:0]          cmd_key,
    input  logic [VAL_W-1:0]          cmd_val,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_status,
    output logic [VAL_W-1:0]          rsp_val,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_re,
    output logic                      mem_we,
    output logic [2+KEY_W+VAL_W-1:0]  mem_wdata,
    input  logic [2+KEY_W+VAL_W-1:0]  mem_rdata
);

    localparam int unsigned ENT_W  = 2 + KEY_W + VAL_W;
    localparam int unsigned NCHUNK = (KEY_W + ADDR_W - 1) / ADDR_W;

    localparam logic [1:0] OpLookup = 2'b00;
    localparam logic [1:0] OpInsert = 2'b01;
    localparam logic [1:0] OpDelete = 2'b10;
    localparam logic [1:0] OpClear  = 2'b11;

    localparam logic [1:0] EntEmpty = 2'b00;
    localparam logic [1:0] EntFull  = 2'b01;
    localparam logic [1:0] EntTomb  = 2'b10;

    localparam logic [1:0] RspOk   = 2'b00;
    localparam logic [1:0] RspMiss = 2'b01;
    localparam logic [1:0] RspFull = 2'b10;
    localparam logic [1:0] RspNew  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCheck,
        StWrite,
        StClr,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  n_q, n_d;
    logic               ff_vld_q, ff_vld_d;
    logic [ADDR_W-1:0]  ff_idx_q, ff_idx_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [ENT_W-1:0]   wr_ent_q, wr_ent_d;
    logic [1:0]         status_q, status_d;
    logic [VAL_W-1:0]   rval_q, rval_d;

    logic [1:0]         rd_st;
    logic [KEY_W-1:0]   rd_key;
    logic [VAL_W-1:0]   rd_val;
    logic               ff_avail;
    logic [ADDR_W-1:0]  ff_at;

    // XOR-fold of the key in ADDR_W-bit chunks, top chunk zero-padded
    function automatic logic [ADDR_W-1:0] hash_key(input logic [KEY_W-1:0] k);
        logic [NCHUNK*ADDR_W-1:0] padded;
        logic [ADDR_W-1:0]        h;
        padded           = '0;
        padded[KEY_W-1:0] = k;
        h                = '0;
        for (int i = 0; i < int'(NCHUNK); i++) begin
            h = h ^ padded[i*ADDR_W +: ADDR_W];
        end
        return h;
    endfunction

    assign rd_st  = mem_rdata[ENT_W-1 -: 2];
    assign rd_key = mem_rdata[KEY_W+VAL_W-1 -: KEY_W];
    assign rd_val = mem_rdata[VAL_W-1:0];

    // A tombstone seen on the current probe counts as a free slot for this decision
    assign ff_avail = ff_vld_q | (rd_st == EntTomb);
    assign ff_at    = ff_vld_q ? ff_idx_q : idx_q;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= '0;
            key_q     <= '0;
            val_q     <= '0;
            idx_q     <= '0;
            n_q       <= '0;
            ff_vld_q  <= 1'b0;
            ff_idx_q  <= '0;
            wr_addr_q <= '0;
            wr_ent_q  <= '0;
            status_q  <= '0;
            rval_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            key_q     <= key_d;
            val_q     <= val_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            ff_vld_q  <= ff_vld_d;
            ff_idx_q  <= ff_idx_d;
            wr_addr_q <= wr_addr_d;
            wr_ent_q  <= wr_ent_d;
            status_q  <= status_d;
            rval_q    <= rval_d;
        end
    end

    // Next-state: command accept, probe evaluation, clear sweep, response handshake
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        key_d     = key_q;
        val_d     = val_q;
        idx_d     = idx_q;
        n_d       = n_q;
        ff_vld_d  = ff_vld_q;
        ff_idx_d  = ff_idx_q;
        wr_addr_d = wr_addr_q;
        wr_ent_d  = wr_ent_q;
        status_d  = status_q;
        rval_d    = rval_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d     = cmd_op;
                    key_d    = cmd_key;
                    val_d    = cmd_val;
                    n_d      = '0;
                    ff_vld_d = 1'b0;
                    rval_d   = '0;
                    status_d = RspOk;
                    if (cmd_op == OpClear) begin
                        idx_d   = '0;
                        state_d = StClr;
                    end else begin
                        idx_d   = hash_key(cmd_key);
                        state_d = StRead;
                    end
                end
            end
            StRead: state_d = StCheck;
            StCheck: begin
                if (rd_st == EntFull && rd_key == key_q) begin
                    status_d  = RspOk;
                    wr_addr_d = idx_q;
                    case (op_q)
                        OpLookup: begin
                            rval_d  = rd_val;
                            state_d = StResp;
                        end
                        OpInsert: begin
                            wr_ent_d = {EntFull, key_q, val_q};
                            state_d  = StWrite;
                        end
                        OpDelete: begin
                            wr_ent_d = {EntTomb, rd_key, rd_val};
                            state_d  = StWrite;
                        end
                        default: state_d = StResp;
                    endcase
                end else if (rd_st == EntEmpty) begin
                    if (op_q == OpInsert) begin
                        wr_addr_d = ff_vld_q ? ff_idx_q : idx_q;
                        wr_ent_d  = {EntFull, key_q, val_q};
                        status_d  = RspNew;
                        state_d   = StWrite;
                    end else begin
                        status_d = RspMiss;
                        state_d  = StResp;
                    end
                end else begin
                    // Tombstone or foreign key: remember first free slot, keep probing
                    if (rd_st == EntTomb && !ff_vld_q) begin
                        ff_vld_d = 1'b1;
                        ff_idx_d = idx_q;
                    end
                    if (n_q == '1) begin
                        if (op_q == OpInsert && ff_avail) begin
                            wr_addr_d = ff_at;
                            wr_ent_d  = {EntFull, key_q, val_q};
                            status_d  = RspNew;
                            state_d   = StWrite;
                        end else begin
                            status_d = (op_q == OpInsert) ? RspFull : RspMiss;
                            state_d  = StResp;
                        end
                    end else begin
                        n_d     = n_q + 1'b1;
                        idx_d   = idx_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StWrite: state_d = StResp;
            StClr: begin
                if (idx_q == '1) begin
                    status_d = RspOk;
                    state_d  = StResp;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state; memory strobes are mutually exclusive
    always_comb begin
        cmd_ready  = (state_q == StIdle);
        rsp_valid  = (state_q == StResp);
        rsp_status = status_q;
        rsp_val    = rval_q;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            StRead: begin
                mem_re   = 1'b1;
                mem_addr = idx_q;
            end
            StWrite: begin
                mem_we    = 1'b1;
                mem_addr  = wr_addr_q;
                mem_wdata = wr_ent_q;
            end
            StClr: begin
                mem_we   = 1'b1;
                mem_addr = idx_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hash_table_ctrl.sv
// Self-checking bench for hash_table_ctrl: directed scenarios plus randomized
// commands compared against a behavioural hash-table model.
module tb_hash_table_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_key;
    logic [7:0]  cmd_val;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [7:0]  rsp_val;
    logic [3:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [17:0] mem_wdata;
    logic [17:0] mem_rdata;

    hash_table_ctrl #(
        .KEY_W  (8),
        .VAL_W  (8),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_key    (cmd_key),
        .cmd_val    (cmd_val),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_val    (rsp_val),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Slot RAM and bus monitors
    logic [17:0] ram [16];
    int          wr_cnt   = 0;
    int          both_cnt = 0;
    int          stray    = 0;
    logic [3:0]  last_waddr = '0;
    logic [17:0] last_wdata = '0;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            last_waddr    <= mem_addr;
            last_wdata    <= mem_wdata;
        end
        if (mem_re) mem_rdata <= ram[mem_addr];
        if (mem_re && mem_we) both_cnt <= both_cnt + 1;
        if ((mem_re || mem_we) && (cmd_ready || rsp_valid)) stray <= stray + 1;
    end

    // Reference model state and results of the last command
    logic [17:0] ref_mem [16];
    logic [1:0]  exp_st;
    logic [7:0]  exp_val;
    int          exp_lat, exp_nwr;
    logic [3:0]  exp_waddr;
    logic [17:0] exp_wdata;
    logic [1:0]  got_st;
    logic [7:0]  got_val;
    int          got_lat, got_nwr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Hash table semantics at the level of "scan the probe sequence"
    task automatic model_cmd(input logic [1:0] op, input logic [7:0] key, input logic [7:0] val);
        int h, idx, ff, hit, empty, probes;
        logic [17:0] e;
        exp_val = '0; exp_nwr = 0; exp_waddr = '0; exp_wdata = '0;
        if (op == 2'b11) begin
            for (int i = 0; i < 16; i++) ref_mem[i] = '0;
            exp_st = 2'b00; exp_lat = 17; exp_nwr = 16; exp_waddr = 4'hf;
            return;
        end
        h = int'(key[7:4] ^ key[3:0]);
        ff = -1; hit = -1; empty = -1; probes = 0; e = '0;
        for (int n = 0; n < 16; n++) begin
            idx    = (h + n) % 16;
            e      = ref_mem[idx];
            probes = n + 1;
            if (e[17:16] == 2'b01 && e[15:8] == key) begin hit = idx; break; end
            if (e[17:16] == 2'b00) begin empty = idx; break; end
            if (e[17:16] == 2'b10 && ff < 0) ff = idx;
        end
        if (hit >= 0) begin
            exp_st = 2'b00;
            if (op == 2'b00) exp_val = e[7:0];
            else begin
                exp_nwr   = 1;
                exp_waddr = 4'(hit);
                exp_wdata = (op == 2'b01) ? {2'b01, key, val} : {2'b10, e[15:0]};
            end
        end else if (op == 2'b01 && (empty >= 0 || ff >= 0)) begin
            exp_st    = 2'b11;
            exp_nwr   = 1;
            exp_waddr = 4'((ff >= 0) ? ff : empty);
            exp_wdata = {2'b01, key, val};
        end else begin
            exp_st = (op == 2'b01) ? 2'b10 : 2'b01;
        end
        if (exp_nwr == 1) ref_mem[exp_waddr] = exp_wdata;
        exp_lat = 2 * probes + 1 + exp_nwr;
    endtask

    // Issue one command, check the response against the model, hold rsp_ready low for `hold` cycles
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] key, input logic [7:0] val,
                           input int hold);
        int  cyc;
        int  start_wr;
        bit  seen;
        model_cmd(op, key, val);
        @(negedge clk);
        cyc = 0;
        while (!cmd_ready && cyc < 200) begin @(negedge clk); cyc++; end
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        start_wr  = wr_cnt;
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_val = val;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_key = 8'($urandom);
        cmd_val = 8'($urandom);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("rsp_seen", 32'(seen), 32'd1);
        got_lat = cyc; got_st = rsp_status; got_val = rsp_val; got_nwr = wr_cnt - start_wr;
        check_eq("latency", 32'(got_lat), 32'(exp_lat));
        check_eq("status", 32'(got_st), 32'(exp_st));
        check_eq("rsp_val", 32'(got_val), 32'(exp_val));
        check_eq("write_count", 32'(got_nwr), 32'(exp_nwr));
        if (exp_nwr >= 1) begin
            check_eq("write_addr", 32'(last_waddr), 32'(exp_waddr));
            check_eq("write_data", 32'(last_wdata), 32'(exp_wdata));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_status", 32'(rsp_status), 32'(exp_st));
            check_eq("hold_val", 32'(rsp_val), 32'(exp_val));
            check_eq("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, k;
        logic [1:0] op;
        for (int i = 0; i < 16; i++) begin ram[i] = '0; ref_mem[i] = '0; end
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_val = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_status", 32'(rsp_status), 32'd0);
        check_eq("rst_rsp_val", 32'(rsp_val), 32'd0);
        check_eq("rst_mem_re", 32'(mem_re), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;

        // Directed sequence from the test plan
        run_cmd(2'b11, 8'h00, 8'h00, 0);
        check_eq("clear_lat", 32'(got_lat), 32'd17);
        run_cmd(2'b01, 8'h12, 8'hAB, 0);
        check_eq("ins12_addr", 32'(last_waddr), 32'd3);
        check_eq("ins12_data", 32'(last_wdata), 32'h112AB);
        check_eq("ins12_st", 32'(got_st), 32'd3);
        check_eq("ins12_lat", 32'(got_lat), 32'd4);
        run_cmd(2'b00, 8'h12, 8'h00, 0);
        check_eq("lk12_st", 32'(got_st), 32'd0);
        check_eq("lk12_val", 32'(got_val), 32'hAB);
        check_eq("lk12_lat", 32'(got_lat), 32'd3);
        run_cmd(2'b01, 8'h21, 8'h55, 0);
        check_eq("ins21_addr", 32'(last_waddr), 32'd4);
        check_eq("ins21_st", 32'(got_st), 32'd3);
        run_cmd(2'b00, 8'h21, 8'h00, 0);
        check_eq("lk21_val", 32'(got_val), 32'h55);
        check_eq("lk21_lat", 32'(got_lat), 32'd5);
        run_cmd(2'b10, 8'h12, 8'h00, 0);
        check_eq("del12_st", 32'(got_st), 32'd0);
        check_eq("del12_data", 32'(last_wdata), 32'h212AB);
        run_cmd(2'b00, 8'h21, 8'h00, 0);
        check_eq("lk21_tomb_st", 32'(got_st), 32'd0);
        check_eq("lk21_tomb_val", 32'(got_val), 32'h55);
        run_cmd(2'b01, 8'h30, 8'h77, 0);
        check_eq("ins30_addr", 32'(last_waddr), 32'd3);
        check_eq("ins30_st", 32'(got_st), 32'd3);

        run_cmd(2'b11, 8'h00, 8'h00, 0);
        run_cmd(2'b00, 8'h99, 8'h00, 0);
        check_eq("lk99_st", 32'(got_st), 32'd1);
        check_eq("lk99_lat", 32'(got_lat), 32'd3);
        check_eq("lk99_nwr", 32'(got_nwr), 32'd0);

        // Fill every slot, then one more insert must report FULL without writing
        run_cmd(2'b11, 8'h00, 8'h00, 0);
        for (int i = 0; i < 16; i++) run_cmd(2'b01, 8'(i), 8'(i + 100), 0);
        run_cmd(2'b01, 8'h10, 8'hEE, 0);
        check_eq("full_st", 32'(got_st), 32'd2);
        check_eq("full_lat", 32'(got_lat), 32'd33);
        check_eq("full_nwr", 32'(got_nwr), 32'd0);

        // Response back-pressure
        run_cmd(2'b11, 8'h00, 8'h00, 0);
        run_cmd(2'b01, 8'h5A, 8'hC3, 0);
        run_cmd(2'b00, 8'h5A, 8'h00, 5);
        check_eq("hold_hit_val", 32'(got_val), 32'hC3);

        // Reset in the middle of a clear sweep
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        k = 0;
        while (!(mem_we && mem_addr == 4'd7) && k < 40) begin @(negedge clk); k++; end
        check_eq("clr_reach_slot7", 32'(mem_addr), 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rstmid_mem_we", 32'(mem_we), 32'd0);
        check_eq("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        run_cmd(2'b11, 8'h00, 8'h00, 0);

        // Randomized commands over a small key pool so the table fills and tombstones accumulate
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            k = int'($urandom_range(0, 23));
            if (r < 3)       op = 2'b11;
            else if (r < 42) op = 2'b01;
            else if (r < 72) op = 2'b00;
            else             op = 2'b10;
            run_cmd(op, 8'(k * 11), 8'($urandom), int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 16; i++) check_eq("ram_contents", 32'(ram[i]), 32'(ref_mem[i]));
        check_eq("re_we_overlap", 32'(both_cnt), 32'd0);
        check_eq("stray_strobe", 32'(stray), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
